// File: rtl/demux_pkg.sv
// Shared types and helpers for the fan speed-line demultiplexer.
package demux_pkg;

   // Fan speed levels, equal to the {s1,s0} select code.
   typedef enum logic [1:0] {
      SPD_OFF  = 2'd0,
      SPD_LOW  = 2'd1,
      SPD_MED  = 2'd2,
      SPD_HIGH = 2'd3
   } spd_e;

   // Width of the ramp step counter (holds up to RAMP_CYCLES-1).
   localparam int CNT_W = 8;

   // Level to one-hot speed lines, bit order {d,c,b,a}.
   function automatic logic [3:0] spd_onehot(input logic [1:0] lvl);
      logic [3:0] oh;
      oh = 4'b0000;
      oh[lvl] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/demux_ramp.sv
// Current-level register with soft-start stepping: upward moves advance one
// level every RAMP_CYCLES cycles, downward moves and disable act at once.
module demux_ramp
   import demux_pkg::*;
#(
   parameter int RAMP_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [1:0] tgt_i,
   output logic [1:0] lvl_o
);

   logic [1:0]       lvl_q, lvl_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(RAMP_CYCLES - 1);

   // Next level/counter: disable clears, lower target loads, higher target steps.
   always_comb begin
      lvl_d = lvl_q;
      cnt_d = '0;
      if (!en_i) begin
         lvl_d = SPD_OFF;
      end else if (tgt_i > lvl_q) begin
         if (cnt_q >= CntLast) begin
            lvl_d = lvl_q + 2'd1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (tgt_i < lvl_q) begin
         lvl_d = tgt_i;
      end
   end

   // Level and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lvl_q <= SPD_OFF;
         cnt_q <= '0;
      end else begin
         lvl_q <= lvl_d;
         cnt_q <= cnt_d;
      end
   end

   assign lvl_o = lvl_q;

endmodule

// File: rtl/demux.sv
// Registered 1-to-4 fan speed-line demultiplexer. Routes i to one of a..d
// selected by {s1,s0}, gated by e. Defining DEMUX_RAMP_EN adds soft-start
// ramping of upward speed changes (RAMP_CYCLES cycles per level).
module demux
   import demux_pkg::*;
#(
   parameter int RAMP_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic s1,
   input  logic s0,
   input  logic e,
   input  logic i,
   output logic a,
   output logic b,
   output logic c,
   output logic d
);

   logic       act_q, act_d;
   logic [1:0] tgt;
   logic [1:0] lvl;
   logic [3:0] lines;

   assign tgt   = {s1, s0};
   assign act_d = e & i;

`ifdef DEMUX_RAMP_EN
   demux_ramp #(.RAMP_CYCLES(RAMP_CYCLES)) u_ramp (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (act_d),
      .tgt_i (tgt),
      .lvl_o (lvl)
   );
`else
   logic [1:0] lvl_q, lvl_d;

   // Without ramping the level simply follows the target (OFF when inactive).
   always_comb begin
      lvl_d = act_d ? tgt : SPD_OFF;
   end

   // Level register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) lvl_q <= SPD_OFF;
      else        lvl_q <= lvl_d;
   end

   assign lvl = lvl_q;
`endif

   // Registered active flag; the lines are a pure decode of registers.
   always_ff @(posedge clk) begin
      if (!rst_n) act_q <= 1'b0;
      else        act_q <= act_d;
   end

   // One-hot decode of the current level, blanked while inactive.
   always_comb begin
      lines = act_q ? spd_onehot(lvl) : 4'b0000;
   end

   assign {d, c, b, a} = lines;

   // RAMP_CYCLES must fit the step counter and be non-zero.
   a_ramp_range: assert property (@(posedge clk) (RAMP_CYCLES >= 1) && (RAMP_CYCLES <= 255));

endmodule

// File: tb/tb_demux.sv
// Directed self-checking bench for demux; expected line patterns {d,c,b,a}
// are hand-derived constants.
module tb_demux;

   logic clk = 1'b0;
   logic rst_n, s1, s0, e, i;
   logic a, b, c, d;
   int   errs = 0;
   int   total = 0;

   wire [3:0] outs = {d, c, b, a};

   demux #(.RAMP_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s1    (s1),
      .s0    (s0),
      .e     (e),
      .i     (i),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      total++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %b want %b", tag, got, exp);
      end
   endtask

   // Advance n rising edges, leaving time 1ns past the last edge.
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sel(input logic [1:0] v);
      {s1, s0} = v;
   endtask

   logic [3:0] exp_oh [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

   initial begin
      rst_n = 1'b0; e = 1'b1; i = 1'b1; sel(2'b11);
      step(1);
      chk("reset_1", outs, 4'b0000);
      step(1);
      chk("reset_2", outs, 4'b0000);

      // Disabled sweep
      rst_n = 1'b1; e = 1'b0;
      for (int v = 0; v < 4; v++) begin
         sel(v[1:0]);
         step(1);
         chk($sformatf("dis_sel%0d", v), outs, 4'b0000);
      end

      // Enable at level 0: a appears one edge later
      e = 1'b1; sel(2'b00);
      #1;
      chk("en_pre_edge", outs, 4'b0000);
      step(1);
      chk("en_sel0", outs, 4'b0001);

`ifndef DEMUX_RAMP_EN
      // Enabled sweep: new select not visible before the edge, visible after, stable
      for (int v = 1; v < 4; v++) begin
         sel(v[1:0]);
         #1;
         chk($sformatf("sweep_hold%0d", v), outs, exp_oh[v-1]);
         step(1);
         chk($sformatf("sweep_sel%0d", v), outs, exp_oh[v]);
         step(9);
         chk($sformatf("sweep_stable%0d", v), outs, exp_oh[v]);
      end
      sel(2'b00);
      step(1);
      chk("sweep_back0", outs, 4'b0001);
`else
      // Ramp 0 -> 3: b, c, d each after 4 edges
      sel(2'b11);
      step(3);
      chk("ramp_l0_hold", outs, 4'b0001);
      step(1);
      chk("ramp_l1", outs, 4'b0010);
      step(3);
      chk("ramp_l1_hold", outs, 4'b0010);
      step(1);
      chk("ramp_l2", outs, 4'b0100);
      step(4);
      chk("ramp_l3", outs, 4'b1000);
      step(5);
      chk("ramp_l3_stay", outs, 4'b1000);
      sel(2'b00);
      step(1);
      chk("ramp_drop", outs, 4'b0001);
      // Disable mid-ramp, then re-enable restarts from level 0
      sel(2'b11);
      step(5);
      chk("ramp_mid", outs, 4'b0010);
      e = 1'b0;
      step(1);
      chk("ramp_dis", outs, 4'b0000);
      e = 1'b1;
      step(1);
      chk("ramp_reen", outs, 4'b0001);
      // Reset mid-ramp
      step(5);
      chk("ramp_mid2", outs, 4'b0010);
      rst_n = 1'b0;
      step(1);
      chk("ramp_rst", outs, 4'b0000);
      rst_n = 1'b1;
      step(1);
      chk("ramp_post_rst", outs, 4'b0001);
      sel(2'b00);
      step(1);
`endif

      // Data gating: i=0 blanks, raising i shows c one edge later
      i = 1'b0; sel(2'b10);
      step(1);
      chk("gate_i0", outs, 4'b0000);
      i = 1'b1;
      #1;
      chk("gate_pre_edge", outs, 4'b0000);
      step(1);
`ifndef DEMUX_RAMP_EN
      chk("gate_i1", outs, 4'b0100);
`else
      chk("gate_i1", outs, 4'b0001);
      step(8);
      chk("gate_i1_ramped", outs, 4'b0100);
`endif

      // Disable on the same edge as a select change: disable wins
      e = 1'b0; sel(2'b11);
      step(1);
      chk("simul_dis", outs, 4'b0000);
      e = 1'b1;
      step(1);
`ifndef DEMUX_RAMP_EN
      chk("simul_reen", outs, 4'b1000);
`else
      chk("simul_reen", outs, 4'b0001);
`endif

      // Reset while active has priority
      rst_n = 1'b0;
      step(1);
      chk("rst_active", outs, 4'b0000);
      rst_n = 1'b1; sel(2'b01);
      step(1);
`ifndef DEMUX_RAMP_EN
      chk("rst_release", outs, 4'b0010);
`else
      chk("rst_release", outs, 4'b0001);
`endif

      $display("Result: errors=%0d of %0d checks", errs, total);
      $finish;
   end

   // Global time bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
